mem_responder_4b: RTL and testbench

- Responder end of the val/rdy memory protocol that the processor datapath drives on its imem/dmem ports.
- Accepts mem_req_4B_t requests, performs reads/writes on an internal word-organised array, and returns mem_resp_4B_t responses in order after a fixed latency.
- Used as instruction and data memory behind the pipelined core in simulation and FPGA builds. Supports back-pressure on both sides.

---
 rtl/mem_responder_4b.sv | 198 +++++++++++++++++++
 tb/tb_mem_responder_4b.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_4b.sv
// mem_responder_4b: in-order val/rdy memory responder with fixed latency.
// Ports: clk, reset_n, memreq_{msg,val,rdy}, memresp_{msg,val,rdy}.
package mem_responder_4b_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
  localparam logic [2:0] MEM_INIT  = 3'd2;

endpackage

module mem_responder_4b
  import mem_responder_4b_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 1,
  parameter int RESP_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  mem_req_4B_t  memreq_msg,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  output mem_resp_4B_t memresp_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  // ---------------- handshake / outstanding count
  logic          rst_q;
  logic [CW-1:0] cnt;
  logic          req_fire;
  logic          resp_fire;

  assign memreq_rdy = rst_q && (cnt < CW'(RESP_DEPTH));
  assign req_fire   = memreq_val && memreq_rdy;
  assign resp_fire  = memresp_val && memresp_rdy;

  always_ff @(posedge clk) begin
    rst_q <= reset_n;
    if (!reset_n)
      cnt <= '0;
    else if (req_fire && !resp_fire)
      cnt <= cnt + CW'(1);
    else if (!req_fire && resp_fire)
      cnt <= cnt - CW'(1);
  end

  // ---------------- array access
  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [2:0]    nbytes;
  logic [31:0]   rword;
  logic [31:0]   shifted;
  logic [31:0]   rdata;
  logic [31:0]   wdata;
  logic          is_wr;
  logic          wen;
  int            ob;
  int            nb;

  assign idx    = memreq_msg.addr[AW+1:2];
  assign off    = memreq_msg.addr[1:0];
  assign nbytes = (memreq_msg.len == 2'd0) ? 3'd4
                : {1'b0, memreq_msg.len};
  assign ob     = int'(off);
  assign nb     = int'(nbytes);
  assign rword  = mem[idx];
  assign is_wr  = (memreq_msg.type_ == MEM_WRITE)
               || (memreq_msg.type_ == MEM_INIT);
  // a request coinciding with a reset edge is not accepted
  assign wen    = req_fire && reset_n && is_wr;

  // upper address bits alias onto the array
  logic unused_addr;
  assign unused_addr = ^memreq_msg.addr[31:AW+2];

  // lanes past byte 3 fall off both the read and the write
  always_comb begin
    shifted = rword >> {off, 3'b000};
    rdata   = '0;
    wdata   = rword;
    for (int b = 0; b < 4; b++) begin
      if (b < nb)
        rdata[8*b +: 8] = shifted[8*b +: 8];
      if (b >= ob && b < ob + nb)
        wdata[8*b +: 8] = memreq_msg.data[8*(b-ob) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wen)
      mem[idx] <= wdata;
  end

  mem_resp_4B_t new_resp;

  always_comb begin
    new_resp        = '0;
    new_resp.type_  = memreq_msg.type_;
    new_resp.opaque = memreq_msg.opaque;
    new_resp.len    = memreq_msg.len;
    new_resp.test   = 2'd0;
    if (memreq_msg.type_ == MEM_READ)
      new_resp.data = rdata;
  end

  // ---------------- delay line
  // The FIFO write is the last of LATENCY edges, so the line
  // itself holds LATENCY-1 registered stages.
  logic         push_v;
  mem_resp_4B_t push_m;

  if (LATENCY == 1) begin : g_direct
    assign push_v = req_fire;
    assign push_m = new_resp;
  end else begin : g_dl
    logic         dv [LATENCY-1];
    mem_resp_4B_t dm [LATENCY-1];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int k = 0; k < LATENCY-1; k++)
          dv[k] <= 1'b0;
      end else begin
        dv[0] <= req_fire;
        for (int k = 1; k < LATENCY-1; k++)
          dv[k] <= dv[k-1];
      end
    end

    always_ff @(posedge clk) begin
      dm[0] <= new_resp;
      for (int k = 1; k < LATENCY-1; k++)
        dm[k] <= dm[k-1];
    end

    assign push_v = dv[LATENCY-2];
    assign push_m = dm[LATENCY-2];
  end

  // ---------------- response FIFO
  // cnt bounds line+FIFO occupancy, so a push never meets a full FIFO.
  mem_resp_4B_t  fifo [RESP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fcnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign memresp_val = (fcnt != '0);
  assign memresp_msg = fifo[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push_v)
        wr_ptr <= nxt(wr_ptr);
      if (resp_fire)
        rd_ptr <= nxt(rd_ptr);
      if (push_v && !resp_fire)
        fcnt <= fcnt + CW'(1);
      else if (!push_v && resp_fire)
        fcnt <= fcnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_v)
      fifo[wr_ptr] <= push_m;
  end

endmodule

// File: tb/tb_mem_responder_4b.sv
// tb_mem_responder_4b: directed bench for mem_responder_4b.
// Instance a: LATENCY=1 RESP_DEPTH=2; instance b: LATENCY=3 RESP_DEPTH=4.
module tb_mem_responder_4b;
  import mem_responder_4b_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  mem_req_4B_t  a_req, b_req;
  logic         a_req_val, b_req_val;
  logic         a_req_rdy, b_req_rdy;
  mem_resp_4B_t a_resp, b_resp;
  logic         a_resp_val, b_resp_val;
  logic         a_resp_rdy, b_resp_rdy;

  mem_responder_4b #(
    .MEM_WORDS(1024), .LATENCY(1), .RESP_DEPTH(2)
  ) dut_a (
    .clk(clk), .reset_n(reset_n),
    .memreq_msg(a_req), .memreq_val(a_req_val),
    .memreq_rdy(a_req_rdy),
    .memresp_msg(a_resp), .memresp_val(a_resp_val),
    .memresp_rdy(a_resp_rdy)
  );

  mem_responder_4b #(
    .MEM_WORDS(1024), .LATENCY(3), .RESP_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n),
    .memreq_msg(b_req), .memreq_val(b_req_val),
    .memreq_rdy(b_req_rdy),
    .memresp_msg(b_resp), .memresp_val(b_resp_val),
    .memresp_rdy(b_resp_rdy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  mem_resp_4B_t q[$];
  int           qcyc[$];

  always @(posedge clk)
    if (a_resp_val && a_resp_rdy) begin
      q.push_back(a_resp);
      qcyc.push_back(cyc);
    end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout got 0 want 1", nm);
  endtask

  // one request on instance a, resp_rdy high, wait for its response
  task automatic xact(input logic [2:0] t, input logic [7:0] op,
                      input logic [31:0] ad, input logic [1:0] ln,
                      input logic [31:0] d,
                      output mem_resp_4B_t r, output int lat);
    int g;
    a_req     = '{t, op, ad, ln, d};
    a_req_val = 1'b1;
    g = 0;
    while (!a_req_rdy && g < 20) begin
      tick();
      g++;
    end
    if (g >= 20) bound_fail("xact rdy");
    tick();
    a_req_val = 1'b0;
    lat = 1;
    while (!a_resp_val && lat < 20) begin
      tick();
      lat++;
    end
    if (lat >= 20) bound_fail("xact resp");
    r = a_resp;
    tick();
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    mem_resp_4B_t r, m0;
    int lat;

    vt.push_back('{MEM_INIT,  8'h01, 32'h100, 2'd0, 32'hDEADBEEF, 32'h0});
    vt.push_back('{MEM_READ,  8'h5A, 32'h100, 2'd0, 32'h0, 32'hDEADBEEF});
    vt.push_back('{MEM_WRITE, 8'h02, 32'h102, 2'd1, 32'h77, 32'h0});
    vt.push_back('{MEM_READ,  8'h03, 32'h102, 2'd2, 32'h0, 32'h0000DE77});
    vt.push_back('{MEM_READ,  8'h04, 32'h101, 2'd1, 32'h0, 32'h000000BE});
    vt.push_back('{MEM_READ,  8'h05, 32'h103, 2'd0, 32'h0, 32'h000000DE});
    vt.push_back('{MEM_INIT,  8'h06, 32'h200, 2'd0, 32'h01020304, 32'h0});
    vt.push_back('{MEM_WRITE, 8'h07, 32'h201, 2'd3, 32'h00A1B2C3, 32'h0});
    vt.push_back('{MEM_READ,  8'h08, 32'h200, 2'd0, 32'h0, 32'hA1B2C304});
    vt.push_back('{MEM_WRITE, 8'h09, 32'h203, 2'd2, 32'h0000FFEE, 32'h0});
    vt.push_back('{MEM_READ,  8'h0A, 32'h200, 2'd0, 32'h0, 32'hEEB2C304});
    vt.push_back('{3'd3,      8'h0B, 32'h200, 2'd0, 32'h55555555, 32'h0});
    vt.push_back('{MEM_READ,  8'h0C, 32'h200, 2'd3, 32'h0, 32'h00B2C304});
    vt.push_back('{MEM_READ,  8'h0D, 32'h202, 2'd0, 32'h0, 32'h0000EEB2});

    reset_n    = 1'b0;
    a_req_val  = 1'b0;
    b_req_val  = 1'b0;
    a_resp_rdy = 1'b1;
    b_resp_rdy = 1'b1;
    a_req      = '0;
    b_req      = '0;
    repeat (2) tick();
    chk("rst a val", a_resp_val, 0);
    chk("rst a rdy", a_req_rdy, 0);
    chk("rst b val", b_resp_val, 0);
    chk("rst b rdy", b_req_rdy, 0);
    reset_n = 1'b1;
    tick();
    chk("post rst a rdy", a_req_rdy, 1);
    chk("post rst b rdy", b_req_rdy, 1);

    // ---- table of single transactions
    foreach (vt[i]) begin
      xact(vt[i].t, vt[i].op, vt[i].addr, vt[i].len, vt[i].data,
           r, lat);
      chk($sformatf("vec%0d data", i), r.data, vt[i].exp);
      chk($sformatf("vec%0d echo", i),
          {r.type_, r.opaque, r.test, r.len},
          {vt[i].t, vt[i].op, 2'd0, vt[i].len});
      chk($sformatf("vec%0d lat", i), lat, 1);
    end

    // ---- throughput: 16 back-to-back reads
    q.delete();
    qcyc.delete();
    a_req_val = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_req = '{MEM_READ, 8'(i), 32'h100, 2'd0, 32'h0};
      chk($sformatf("tput rdy%0d", i), a_req_rdy, 1);
      tick();
    end
    a_req_val = 1'b0;
    repeat (3) tick();
    chk("tput count", q.size(), 16);
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      chk($sformatf("tput op%0d", i), q[i].opaque, i);
      chk($sformatf("tput data%0d", i), q[i].data, 32'hDE77BEEF);
      if (i > 0)
        chk($sformatf("tput gap%0d", i), qcyc[i] - qcyc[i-1], 1);
    end

    // ---- aliasing + read right after write
    q.delete();
    a_req     = '{MEM_WRITE, 8'h01, 32'h1000, 2'd0, 32'h11};
    a_req_val = 1'b1;
    tick();
    a_req = '{MEM_READ, 8'h02, 32'h0000, 2'd0, 32'h0};
    tick();
    a_req_val = 1'b0;
    repeat (3) tick();
    chk("raw count", q.size(), 2);
    if (q.size() >= 2) begin
      chk("raw wr data", q[0].data, 0);
      chk("raw rd data", q[1].data, 32'h11);
      chk("raw rd op", q[1].opaque, 8'h02);
    end

    // ---- back-pressure
    q.delete();
    a_resp_rdy = 1'b0;
    a_req_val  = 1'b1;
    a_req = '{MEM_READ, 8'd0, 32'h100, 2'd0, 32'h0};
    chk("bp rdy0", a_req_rdy, 1);
    tick();
    a_req = '{MEM_READ, 8'd1, 32'h101, 2'd1, 32'h0};
    chk("bp rdy1", a_req_rdy, 1);
    tick();
    a_req = '{MEM_READ, 8'd2, 32'h102, 2'd1, 32'h0};
    chk("bp rdy low", a_req_rdy, 0);
    chk("bp val", a_resp_val, 1);
    m0 = a_resp;
    tick();
    chk("bp rdy held", a_req_rdy, 0);
    chk("bp stable", a_resp, m0);
    a_resp_rdy = 1'b1;
    tick();
    chk("bp reassert", a_req_rdy, 1);
    tick();
    a_req_val = 1'b0;
    repeat (4) tick();
    chk("bp count", q.size(), 3);
    for (int i = 0; i < 3 && i < q.size(); i++)
      chk($sformatf("bp order%0d", i), q[i].opaque, i);
    if (q.size() >= 3) begin
      chk("bp d0", q[0].data, 32'hDE77BEEF);
      chk("bp d1", q[1].data, 32'h000000BE);
      chk("bp d2", q[2].data, 32'h00000077);
    end

    // ---- reset with responses in flight
    xact(MEM_WRITE, 8'h30, 32'h300, 2'd0, 32'h12345678, r, lat);
    a_resp_rdy = 1'b0;
    a_req_val  = 1'b1;
    a_req = '{MEM_READ, 8'hA0, 32'h300, 2'd0, 32'h0};
    tick();
    a_req = '{MEM_READ, 8'hA1, 32'h300, 2'd0, 32'h0};
    tick();
    a_req_val = 1'b0;
    chk("mid val before rst", a_resp_val, 1);
    q.delete();
    reset_n = 1'b0;
    tick();
    chk("mid rst val", a_resp_val, 0);
    chk("mid rst rdy", a_req_rdy, 0);
    reset_n    = 1'b1;
    a_resp_rdy = 1'b1;
    tick();
    chk("mid rel rdy", a_req_rdy, 1);
    chk("mid rel val", a_resp_val, 0);
    repeat (4) tick();
    chk("mid no stale", q.size(), 0);
    xact(MEM_READ, 8'h31, 32'h300, 2'd0, 32'h0, r, lat);
    chk("mid kept wr", r.data, 32'h12345678);

    // ---- latency 3 instance
    b_req     = '{MEM_INIT, 8'h33, 32'h40, 2'd0, 32'hCAFEF00D};
    b_req_val = 1'b1;
    chk("l3 rdy", b_req_rdy, 1);
    tick();
    b_req_val = 1'b0;
    chk("l3 init c1", b_resp_val, 0);
    tick();
    chk("l3 init c2", b_resp_val, 0);
    tick();
    chk("l3 init c3", b_resp_val, 1);
    chk("l3 init msg", {b_resp.type_, b_resp.data}, {MEM_INIT, 32'h0});
    tick();
    b_req     = '{MEM_READ, 8'h34, 32'h40, 2'd0, 32'h0};
    b_req_val = 1'b1;
    chk("l3 rdy2", b_req_rdy, 1);
    tick();
    b_req_val = 1'b0;
    chk("l3 rd c1", b_resp_val, 0);
    tick();
    chk("l3 rd c2", b_resp_val, 0);
    tick();
    chk("l3 rd c3", b_resp_val, 1);
    chk("l3 rd data", b_resp.data, 32'hCAFEF00D);
    chk("l3 rd op", b_resp.opaque, 8'h34);
    tick();
    chk("l3 drained", b_resp_val, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
